uart_rx_oversampled: RTL and testbench



---
 rtl/uart_rx_oversampled.sv | 157 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   8N1 (parameterizable data width) UART receiver driven by an
//   OVERSAMPLE-per-bit tick. The start bit is validated at its centre.
//   Data bits are sampled one full bit period apart after that, so each
//   sample also lands near a bit centre.
//
//   Ports:
//     clk        system clock, posedge
//     rst_n      async active-low reset
//     rx_en      oversample tick (one clk wide, OVERSAMPLE per bit)
//     rx         async serial line, idle high
//     rdy_clr    host consumed data; clears ready/overrun/frame_err
//     data       last correctly framed byte
//     ready      data holds an unconsumed byte
//     frame_err  last stop bit was sampled low
//     overrun    a byte completed while ready was still set
//     busy       FSM not in IDLE
//
//   DATA_BITS must be >= 2. OVERSAMPLE must be a power of two, >= 8.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] MID      = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 ready_d, fe_d, ov_d;
  logic                 rx_m, rx_s;

  // Two-flop synchronizer. It resets to the idle level, so leaving reset
  // never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      data      <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      data      <= data_d;
      ready     <= ready_d;
      frame_err <= fe_d;
      overrun   <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data;
    ready_d = ready;
    fe_d    = frame_err;
    ov_d    = overrun;

    // Host clear goes first so a coincident frame completion below overrides it.
    if (rdy_clr) begin
      ready_d = 1'b0;
      ov_d    = 1'b0;
      fe_d    = 1'b0;
    end

    if (rx_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q != MID) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!rx_s) begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;  // glitch, not a real start bit
          end
        end
        S_DATA: begin
          if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};  // LSB arrives first
            cnt_d = '0;
            if (idx_q == LAST_BIT) state_d = S_STOP;
            else                   idx_d   = idx_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else if (rx_s) begin
            data_d  = sh_q;
            ready_d = 1'b1;
            fe_d    = 1'b0;
            // A clear in the same cycle means the old byte was consumed.
            ov_d    = ready & ~rdy_clr;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end
        S_BREAK: begin
          // Wait for the line to go idle so a held-low line is one error.
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       ready, frame_err, overrun, busy;

  int checks = 0;
  int failures = 0;

  // Frame-level reference state.
  logic [7:0] m_data = 8'h00;
  logic       m_ready = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

  always #5 clk = ~clk;

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx), .rdy_clr(rdy_clr),
    .data(data), .ready(ready), .frame_err(frame_err), .overrun(overrun),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_busy);
    chk({tag, ".data"},      32'(data),      32'(m_data));
    chk({tag, ".ready"},     32'(ready),     32'(m_ready));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
    chk({tag, ".overrun"},   32'(overrun),   32'(m_ov));
    chk({tag, ".busy"},      32'(busy),      32'(exp_busy));
  endtask

  // One oversample period: 3 idle clks then a tick clk (rx_en 1-in-4).
  // The line is set right after the previous tick. An optional glitch
  // inverts it for one clk well before the tick. The call returns on
  // the negedge after the tick edge.
  task automatic tick(input logic lvl, input logic clr, input logic gl);
    rx = lvl ^ gl;
    @(negedge clk);
    rx = lvl;
    @(negedge clk);
    @(negedge clk);
    rx_en = 1'b1;
    rdy_clr = clr;
    @(negedge clk);
    rx_en = 1'b0;
    rdy_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    m_ready = 1'b0;
    m_ov = 1'b0;
    m_fe = 1'b0;
  endtask

  // Sends start, 8 data bits and the stop bit up to its centre sample (T152).
  // The reference state is updated from the frame-level rules.
  task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_lvl,
                            input logic clr_stop, input logic glitchy);
    for (int t = 0; t < 16; t++) begin
      tick(1'b0, 1'b0, glitchy && ($urandom_range(0, 3) == 0));
      if (t == 0) chk({tag, ".busy_T0"}, 32'(busy), 32'd1);
    end
    for (int n = 0; n < 8; n++)
      for (int t = 0; t < 16; t++)
        tick(b[n], 1'b0, glitchy && ($urandom_range(0, 3) == 0));
    for (int t = 0; t < 8; t++) tick(stop_lvl, 1'b0, 1'b0);
    check_outs({tag, ".pre_stop"}, 1'b1);
    tick(stop_lvl, clr_stop, 1'b0);
    if (stop_lvl) begin
      m_ov = m_ready & ~clr_stop;
      m_ready = 1'b1;
      m_data = b;
      m_fe = 1'b0;
    end else begin
      if (clr_stop) begin
        m_ready = 1'b0;
        m_ov = 1'b0;
      end
      m_fe = 1'b1;
    end
    check_outs({tag, ".stop"}, ~stop_lvl);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    check_outs("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check_outs("idle_after_reset", 1'b0);

    // Good frame.
    send_frame("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(8);
    check_outs("a5_after", 1'b0);
    pulse_clr();
    check_outs("a5_clr", 1'b0);

    // False start: low for 4 ticks, then back high before the centre check.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    check_outs("false_T7", 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check_outs("false_T8", 1'b0);
    idle(4);

    // Framing error, then the line is held low.
    send_frame("3c", 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b0);
    check_outs("break_hold", 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check_outs("break_release", 1'b0);
    idle(4);
    check_outs("break_idle", 1'b0);
    pulse_clr();
    check_outs("fe_clr", 1'b0);

    // Overrun.
    send_frame("11", 8'h11, 1'b1, 1'b0, 1'b0);
    idle(7);
    send_frame("22", 8'h22, 1'b1, 1'b0, 1'b0);
    idle(7);
    pulse_clr();
    check_outs("ovr_clr", 1'b0);

    // Clear coincides with the stop tick.
    send_frame("10", 8'h10, 1'b1, 1'b0, 1'b0);
    idle(7);
    send_frame("7e", 8'h7E, 1'b1, 1'b1, 1'b0);
    idle(7);

    // Reset in the middle of bit 4 of 0xFF.
    for (int t = 0; t < 16; t++) tick(1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 72; t++) tick(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    m_data = 8'h00; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    check_outs("mid_reset", 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check_outs("post_reset", 1'b0);
    send_frame("5a", 8'h5A, 1'b1, 1'b0, 1'b0);
    idle(7);

    // Randomized frames with glitches, errors and host clears.
    for (int f = 0; f < 20; f++) begin
      logic [7:0] b;
      logic       good, clr;
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      clr  = ($urandom_range(0, 3) == 0);
      send_frame("rnd", b, good, clr, 1'b1);
      if (!good) begin
        for (int i = 0; i < int'($urandom_range(0, 10)); i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
      end
      idle(int'($urandom_range(1, 4)));
      check_outs("rnd_idle", 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        check_outs("rnd_clr", 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
